// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
// Holds the controller FSM encoding, latency bounds and a byte-parity helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;
    // Counter only ever holds LATENCY-2, so 3 bits cover LAT_MAX.
    localparam int CNT_W   = 3;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enabled synchronous write and registered read port.
// DMEM_PARITY_EN adds one even-parity bit per byte, checked on every read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata,
    output logic                perr
);

    localparam int NB = DATA_W / 8;
`ifdef DMEM_PARITY_EN
    localparam int MEM_W = DATA_W + NB;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  rd_word;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              perr_d, perr_q;

    // Contents survive reset on purpose; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
                    mem[waddr][DATA_W + b] <= byte_parity(wdata[8*b +: 8]);
`endif
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[raddr];
        rdata_d = rdata_q;
        perr_d  = perr_q;
        if (re) begin
            rdata_d = rd_word[DATA_W-1:0];
            perr_d  = 1'b0;
`ifdef DMEM_PARITY_EN
            for (int b = 0; b < NB; b++) begin
                if (byte_parity(rd_word[8*b +: 8]) != rd_word[DATA_W + b]) begin
                    perr_d = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    assign rdata = rdata_q;
    assign perr  = perr_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding valid/ready memory controller, fixed LATENCY accept-to-response.
// Backpressure: response held until rsp_ready; req_ready low unless IDLE. Option: DMEM_PARITY_EN.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             we_d, we_q;
    logic             oor_d, oor_q;
    logic [IDX_W-1:0] addr_d, addr_q;

    logic             accept;
    logic             req_oor;
    logic [IDX_W-1:0] req_idx;
    logic             mem_we;
    logic             mem_re;
    logic [IDX_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic             mem_perr;

    assign accept  = (state_q == IDLE) && req_valid;
    assign req_oor = ({1'b0, req_addr} >= DEPTH_X);
    assign req_idx = req_addr[IDX_W-1:0];
    // Writes land in the array on the accept edge; the response just reports it.
    assign mem_we  = accept && req_we && !req_oor;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        oor_d     = oor_q;
        addr_d    = addr_q;
        mem_re    = 1'b0;
        mem_raddr = addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    oor_d  = req_oor;
                    addr_d = req_idx;
                    if (LATENCY == 1) begin
                        // Entering RESP now, so the read must use the live address.
                        state_d   = RESP;
                        mem_re    = !req_we && !req_oor;
                        mem_raddr = req_idx;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    mem_re  = !we_q && !oor_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .wbe   (req_be),
        .waddr (req_idx),
        .wdata (req_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata),
        .perr  (mem_perr)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = (rsp_valid && !we_q && !oor_q) ? mem_rdata : '0;
    assign rsp_err   = rsp_valid && (oor_q || (!we_q && mem_perr));

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one LATENCY=1 and one LATENCY=4 instance.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic        req_valid4, req_ready4, rsp_valid4, rsp_ready4, rsp_err4;
    logic [31:0] rsp_rdata4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(512), .LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(512), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
    );

    // Issues one request to the selected instance, scrambles inputs after accept,
    // and returns the response plus the number of cycles until rsp_valid.
    task automatic xact(input int which, input logic we, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        if (which == 1) req_valid1 = 1'b1; else req_valid4 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0; req_valid4 = 1'b0;
        req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;
        lat = 1;
        while (((which == 1) ? rsp_valid1 : rsp_valid4) !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = (which == 1) ? rsp_rdata1 : rsp_rdata4;
        er = (which == 1) ? rsp_err1 : rsp_err4;
        if (which == 1) rsp_ready1 = 1'b1; else rsp_ready4 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0; rsp_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid1 = 0; req_valid4 = 0; rsp_ready1 = 0; rsp_ready4 = 0;
        req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({rsp_valid1, rsp_err1, rsp_rdata1} !== 34'd0) begin
            n_bad++; $display("FAIL reset_rsp1: got %b/%b/%h want 0/0/0", rsp_valid1, rsp_err1, rsp_rdata1);
        end
        n_vec++;
        if ({rsp_valid4, rsp_err4, rsp_rdata4} !== 34'd0) begin
            n_bad++; $display("FAIL reset_rsp4: got %b/%b/%h want 0/0/0", rsp_valid4, rsp_err4, rsp_rdata4);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({req_ready1, req_ready4} !== 2'b11) begin
            n_bad++; $display("FAIL reset_ready: got %b want 11", {req_ready1, req_ready4});
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat;
        xact(1, 1'b1, 16'd5, 32'hDEADBEEF, 4'hF, rd, er, lat);
        n_vec++;
        if ({lat, rd, er} !== {32'd1, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL basic_write: got lat %0d data %h err %b want 1 00000000 0", lat, rd, er);
        end
        xact(1, 1'b0, 16'd5, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if ({lat, rd, er} !== {32'd1, 32'hDEADBEEF, 1'b0}) begin
            n_bad++; $display("FAIL basic_read: got lat %0d data %h err %b want 1 deadbeef 0", lat, rd, er);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        xact(1, 1'b1, 16'd7, 32'h11223344, 4'hF, rd, er, lat);
        xact(1, 1'b1, 16'd7, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        xact(1, 1'b0, 16'd7, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if ({rd, er} !== {32'h11BB33DD, 1'b0}) begin
            n_bad++; $display("FAIL byte_enable: got %h err %b want 11bb33dd 0", rd, er);
        end
        xact(1, 1'b1, 16'd7, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        n_vec++;
        if ({rd, er} !== {32'h0, 1'b0}) begin
            n_bad++; $display("FAIL be_zero_rsp: got %h err %b want 00000000 0", rd, er);
        end
        xact(1, 1'b0, 16'd7, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if (rd !== 32'h11BB33DD) begin
            n_bad++; $display("FAIL be_zero_noop: got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        xact(1, 1'b1, 16'd0, 32'h0BADF00D, 4'hF, rd, er, lat);
        xact(1, 1'b0, 16'd600, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if ({rd, er} !== {32'h0, 1'b1}) begin
            n_bad++; $display("FAIL oor_read: got %h err %b want 00000000 1", rd, er);
        end
        xact(1, 1'b1, 16'd512, 32'h55555555, 4'hF, rd, er, lat);
        n_vec++;
        if ({rd, er} !== {32'h0, 1'b1}) begin
            n_bad++; $display("FAIL oor_write: got %h err %b want 00000000 1", rd, er);
        end
        xact(1, 1'b0, 16'd0, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if ({rd, er} !== {32'h0BADF00D, 1'b0}) begin
            n_bad++; $display("FAIL oor_no_alias: got %h err %b want 0badf00d 0", rd, er);
        end
        xact(1, 1'b0, 16'd511, 32'h0, 4'h0, rd, er, lat);
        xact(1, 1'b1, 16'd511, 32'h01020304, 4'hF, rd, er, lat);
        xact(1, 1'b0, 16'd511, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if ({rd, er} !== {32'h01020304, 1'b0}) begin
            n_bad++; $display("FAIL last_word: got %h err %b want 01020304 0", rd, er);
        end
    endtask

    task automatic test_latency4();
        logic [31:0] rd; logic er; int lat;
        xact(4, 1'b1, 16'd9, 32'hCAFEF00D, 4'hF, rd, er, lat);
        n_vec++;
        if ({lat, rd, er} !== {32'd4, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL lat4_write: got lat %0d data %h err %b want 4 00000000 0", lat, rd, er);
        end
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'd9; req_valid4 = 1'b1; rsp_ready4 = 1'b0;
        @(negedge clk);
        // Keep a second request pending: it must not be taken while busy.
        req_addr = 16'd300;
        for (int i = 1; i <= 3; i++) begin
            n_vec++;
            if ({rsp_valid4, req_ready4} !== 2'b00) begin
                n_bad++; $display("FAIL lat4_wait%0d: got valid/ready %b want 00", i, {rsp_valid4, req_ready4});
            end
            @(negedge clk);
        end
        n_vec++;
        if ({rsp_valid4, rsp_rdata4, rsp_err4} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
            n_bad++; $display("FAIL lat4_first: got %b %h %b want 1 cafef00d 0", rsp_valid4, rsp_rdata4, rsp_err4);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({rsp_valid4, req_ready4, rsp_rdata4} !== {2'b10, 32'hCAFEF00D}) begin
                n_bad++; $display("FAIL lat4_hold%0d: got valid/ready %b data %h want 10 cafef00d", i, {rsp_valid4, req_ready4}, rsp_rdata4);
            end
        end
        req_valid4 = 1'b0; rsp_ready4 = 1'b1;
        @(negedge clk);
        rsp_ready4 = 1'b0;
        n_vec++;
        if ({rsp_valid4, req_ready4} !== 2'b01) begin
            n_bad++; $display("FAIL lat4_done: got valid/ready %b want 01", {rsp_valid4, req_ready4});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int stray;
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'd9; req_valid4 = 1'b1;
        @(negedge clk);
        req_valid4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({rsp_valid4, req_ready4, rsp_rdata4} !== {2'b01, 32'h0}) begin
            n_bad++; $display("FAIL rst_mid: got valid/ready %b data %h want 01 00000000", {rsp_valid4, req_ready4}, rsp_rdata4);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        rsp_ready4 = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid4 === 1'b1 || req_ready4 !== 1'b1) stray++;
        end
        rsp_ready4 = 1'b0;
        n_vec++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL rst_stray: got %0d bad cycles want 0", stray);
        end
        xact(4, 1'b0, 16'd9, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if ({lat, rd, er} !== {32'd4, 32'hCAFEF00D, 1'b0}) begin
            n_bad++; $display("FAIL rst_mem_keep4: got lat %0d data %h err %b want 4 cafef00d 0", lat, rd, er);
        end
        xact(1, 1'b0, 16'd5, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if (rd !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL rst_mem_keep1: got %h want deadbeef", rd);
        end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        logic [31:0] rd; logic er; int lat;
        xact(1, 1'b1, 16'd3, 32'h000000F0, 4'hF, rd, er, lat);
        dut.u_array.mem[3][0] = ~dut.u_array.mem[3][0];
        xact(1, 1'b0, 16'd3, 32'h0, 4'h0, rd, er, lat);
        n_vec++;
        if ({rd, er} !== {32'h000000F1, 1'b1}) begin
            n_bad++; $display("FAIL parity_flip: got %h err %b want 000000f1 1", rd, er);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_out_of_range();
        test_latency4();
        test_reset_mid();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL provide parameter ADDR_W, default 16, word-address width.
REQ-003 SHALL provide parameter DEPTH, default 512, number of words (not required to be a power of two; DEPTH <= 2**ADDR_W).
REQ-004 SHALL provide parameter LATENCY, default 1, request-accept to response cycles, legal range 1..8.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  controller can accept a request.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDR_W  word address.
REQ-011 SHALL have port req_wdata  input  DATA_W  write data.
REQ-012 SHALL have port req_be  input  DATA_W/8  byte enables, bit i covers bits 8i+7:8i.
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-015 SHALL have port rsp_rdata  output  DATA_W  read data, 0 for writes.
REQ-016 SHALL have port rsp_err  output  1  response error flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-018 SHALL accept a request on a rising edge where req_valid&req_ready; IDLE->WAIT if LATENCY>1, IDLE->RESP if LATENCY==1.
REQ-019 SHALL latch req_we, req_addr, req_wdata, req_be at accept; later input changes are ignored.
REQ-020 SHALL hold in WAIT for exactly LATENCY-1 cycles via a down-counter, so rsp_valid first asserts LATENCY cycles after accept.
REQ-021 SHALL commit a write at the accept edge, updating only bytes with req_be=1; other bytes unchanged.
REQ-022 SHALL capture read data from the latched address on the edge entering RESP; rsp_rdata stable while rsp_valid=1.
REQ-023 SHALL hold rsp_valid, rsp_rdata, rsp_err in RESP until rsp_valid&rsp_ready, then go RESP->IDLE; no new request accepted in that same cycle.
REQ-024 SHALL treat req_addr >= DEPTH as out-of-range: write suppressed, rsp_rdata=0, rsp_err=1.
REQ-025 SHALL treat a write with req_be all zero as a legal no-op with rsp_err=0.
REQ-026 SHALL give rsp_rdata=0 for every write response.

Reset
REQ-027 SHALL on rst=1, regardless of clock, force state IDLE, counter 0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 SHALL not clear memory contents on reset; a write committed before reset remains.
REQ-029 SHALL discard any in-flight response when reset asserts mid-operation; no response follows reset release.

Configuration
REQ-030 SHALL, with macro DMEM_PARITY_EN defined, store one even-parity bit per byte, recompute on read, and set rsp_err=1 on mismatch (read data still returned).
REQ-031 SHALL, without DMEM_PARITY_EN, store no parity bits; rsp_err reflects only out-of-range.

Structure
REQ-032 SHALL place FSM state enum type and LATENCY min/max constants in shared package dmem_pkg.
REQ-033 SHALL isolate storage in sub-module dmem_array (byte-enabled synchronous write, registered read, optional parity).

Verification
REQ-034 SHALL cover: LATENCY=1, write addr 5 data 0xDEADBEEF be 4'hF, then read addr 5 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 1 cycle after each accept.
REQ-035 SHALL cover: write 0x11223344 to addr 7, then write 0xAABBCCDD be 4'b0101 -> read addr 7 returns 0x11BB33DD.
REQ-036 SHALL cover: DEPTH=512, read addr 600 -> rsp_rdata 0, rsp_err 1; write addr 512 then read addr 0 unchanged.
REQ-037 SHALL cover: LATENCY=4, rsp_ready held 0 for 3 cycles -> rsp_valid asserts 4 cycles after accept, data stable, req_ready 0 until handshake.
REQ-038 SHALL cover: rst asserted in WAIT of a read -> rsp_valid 0 immediately, req_ready 1 after release, no stray response.
REQ-039 SHALL cover (DMEM_PARITY_EN): force flip of stored bit at addr 3 -> read returns flipped data with rsp_err 1.
